// File: rtl/tt_pin_pkg.sv
// Shared constants and FSM state type for the tile pin driver.
// Fixed pin map: ui = {mode, a}, uio = {cin, 0, b}.
package tt_pin_pkg;

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_LATCH = 2'd1;
  localparam logic [1:0] MODE_RSVD2 = 2'd2;
  localparam logic [1:0] MODE_RSVD3 = 2'd3;

  localparam int UI_CTRL_LSB = 6;
  localparam int UIO_CIN_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/tt_drv_model.sv
// Reference model of the tile: registers the expected output byte at request accept.
// Mode 1 (latch) is clock-phase dependent on the tile, so it is never checked.
module tt_drv_model
  import tt_pin_pkg::*;
#(
  parameter int WIRE = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [1:0]      mode_i,
  input  logic [WIRE-1:0] a_i,
  input  logic [WIRE-1:0] b_i,
  input  logic            cin_i,
  output logic [7:0]      exp_o,
  output logic            chk_o
);

  logic [WIRE:0] sum_w;
  logic [7:0]    exp_q, exp_d;
  logic          chk_q, chk_d;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{WIRE{1'b0}}, cin_i};

  always_comb begin
    exp_d = exp_q;
    chk_d = chk_q;
    if (load_i) begin
      exp_d = (mode_i == MODE_ADD) ? {1'b0, sum_w} : 8'h00;
      chk_d = (mode_i != MODE_LATCH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 8'h00;
      chk_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      chk_q <= chk_d;
    end
  end

  assign exp_o = exp_q;
  assign chk_o = chk_q;

endmodule

// File: rtl/tt_pin_driver.sv
// Host-side initiator for the muxed-pin tile: drives ui/uio, waits SETTLE cycles, samples uo.
// Optional reference check enabled by TT_PIN_DRIVER_CHECK_EN (drives rsp_err).
module tt_pin_driver
  import tt_pin_pkg::*;
#(
  parameter int WIRE   = 6,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_mode,
  input  logic [WIRE-1:0] req_a,
  input  logic [WIRE-1:0] req_b,
  input  logic            req_cin,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [7:0]      rsp_data,
  output logic [1:0]      rsp_mode,
  output logic            rsp_err,
  output logic [7:0]      pin_ui,
  output logic [7:0]      pin_uio,
  input  logic [7:0]      pin_uo
);

  if (WIRE != 6) begin : g_bad_wire
    $error("tt_pin_driver: WIRE must be 6 to fit the fixed pin map");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("tt_pin_driver: SETTLE must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pin_ui_q, pin_ui_d;
  logic [7:0] pin_uio_q, pin_uio_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_mode_q, rsp_mode_d;
  logic       accept;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef TT_PIN_DRIVER_CHECK_EN
  logic [7:0] model_exp;
  logic       model_chk;
  logic       rsp_err_q, rsp_err_d;

  tt_drv_model #(.WIRE(WIRE)) u_model (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .mode_i (req_mode),
    .a_i    (req_a),
    .b_i    (req_b),
    .cin_i  (req_cin),
    .exp_o  (model_exp),
    .chk_o  (model_chk)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pin_ui_d    = pin_ui_q;
    pin_uio_d   = pin_uio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mode_d  = rsp_mode_q;
`ifdef TT_PIN_DRIVER_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pin_ui_d                        = 8'h00;
          pin_ui_d[UI_CTRL_LSB +: 2]      = req_mode;
          pin_ui_d[WIRE-1:0]              = req_a;
          pin_uio_d                       = 8'h00;
          pin_uio_d[UIO_CIN_BIT]          = req_cin;
          pin_uio_d[WIRE-1:0]             = req_b;
          rsp_mode_d                      = req_mode;
          cnt_d                           = CNT_INIT;
          state_d                         = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Tile output is sampled raw, including phase-dependent latch mode.
          rsp_data_d  = pin_uo;
          rsp_valid_d = 1'b1;
`ifdef TT_PIN_DRIVER_CHECK_EN
          rsp_err_d   = model_chk && (pin_uo != model_exp);
`endif
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pin_ui_q    <= 8'h00;
      pin_uio_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_mode_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pin_ui_q    <= pin_ui_d;
      pin_uio_q   <= pin_uio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mode_q  <= rsp_mode_d;
    end
  end

`ifdef TT_PIN_DRIVER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_d;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign pin_ui    = pin_ui_q;
  assign pin_uio   = pin_uio_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_mode  = rsp_mode_q;

endmodule
